// File: rtl/debounce_defs.sv
// ============================================================================
//  Module      : debounce_defs (package)
//  Description : Shared state encoding and default window width for the
//                switch debouncer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package debounce_defs;

    localparam int C_DEFAULT_N = 21;

    typedef enum logic [1:0] {
        ZERO  = 2'b00,
        WAIT1 = 2'b01,
        ONE   = 2'b10,
        WAIT0 = 2'b11
    } db_state_t;

endpackage

`default_nettype wire

// File: rtl/db_fsm_ch.sv
// ============================================================================
//  Module      : db_fsm_ch
//  Description : One debounce channel: optional 2-FF synchroniser, filter FSM
//                with N-bit down-counter, registered level and rising tick.
//                Synchroniser present when DEBOUNCE_SYNC_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module db_fsm_ch
    import debounce_defs::*;
#(
    parameter int N = C_DEFAULT_N
) (
    input  logic clk,
    input  logic reset,
    input  logic sw,
    output logic db_level,
    output logic db_tick
);

    localparam logic [N-1:0] C_CNT_MAX = {N{1'b1}};
    localparam logic [N-1:0] C_CNT_ONE = N'(1);
    localparam logic [N-1:0] C_CNT_ZERO = '0;

    logic           w_s;
    db_state_t      r_state;
    db_state_t      w_state_next;
    logic [N-1:0]   r_cnt;
    logic [N-1:0]   w_cnt_next;
    logic           r_level;
    logic           r_tick;

`ifdef DEBOUNCE_SYNC_EN
    logic [1:0] r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= 2'b00;
        end else begin
            r_sync <= {r_sync[0], sw};
        end
    end

    assign w_s = r_sync[1];
`else
    assign w_s = sw;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ZERO;
            r_cnt   <= C_CNT_ZERO;
            r_level <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            // Level follows the settled half of the state space one cycle later.
            r_level <= r_state[1];
            r_tick  <= r_state[1] & ~r_level;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ZERO: begin
                if (w_s) begin
                    w_state_next = WAIT1;
                    w_cnt_next   = C_CNT_MAX;
                end
            end
            WAIT1: begin
                if (!w_s) begin
                    w_state_next = ZERO;
                end else if (r_cnt <= C_CNT_ONE) begin
                    w_state_next = ONE;
                    w_cnt_next   = C_CNT_ZERO;
                end else begin
                    w_cnt_next   = r_cnt - C_CNT_ONE;
                end
            end
            ONE: begin
                if (!w_s) begin
                    w_state_next = WAIT0;
                    w_cnt_next   = C_CNT_MAX;
                end
            end
            WAIT0: begin
                if (w_s) begin
                    w_state_next = ONE;
                end else if (r_cnt <= C_CNT_ONE) begin
                    w_state_next = ZERO;
                    w_cnt_next   = C_CNT_ZERO;
                end else begin
                    w_cnt_next   = r_cnt - C_CNT_ONE;
                end
            end
            default: begin
                w_state_next = ZERO;
                w_cnt_next   = C_CNT_ZERO;
            end
        endcase
    end

    assign db_level = r_level;
    assign db_tick  = r_tick;

endmodule

`default_nettype wire

// File: rtl/switch_debounce_3.sv
// ============================================================================
//  Module      : switch_debounce_3
//  Description : Three independent switch debounce channels feeding the AND
//                stage. Define DEBOUNCE_SYNC_EN to add input synchronisers.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module switch_debounce_3
    import debounce_defs::*;
#(
    parameter int N = C_DEFAULT_N
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] sw,
    output logic [2:0] db_level,
    output logic [2:0] db_tick
);

    for (genvar i = 0; i < 3; i++) begin : g_ch
        db_fsm_ch #(
            .N(N)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .sw       (sw[i]),
            .db_level (db_level[i]),
            .db_tick  (db_tick[i])
        );
    end

endmodule

`default_nettype wire

// File: tb/tb_switch_debounce_3.sv
// ============================================================================
//  Module      : tb_switch_debounce_3
//  Description : Directed self-checking bench for switch_debounce_3 (N=3).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_switch_debounce_3;

`ifdef DEBOUNCE_SYNC_EN
    localparam int C_SYNC = 2;
`else
    localparam int C_SYNC = 0;
`endif
    // Edges after a change on sw during which the level must not yet move.
    localparam int C_LAT = 8 + C_SYNC;

    logic       clk;
    logic       reset;
    logic [2:0] sw;
    logic [2:0] db_level;
    logic [2:0] db_tick;

    int checks;
    int errors;

    typedef struct {
        logic [2:0] sw;
        int         n;
        logic [2:0] level;
        logic [2:0] tick;
    } vec_t;

    vec_t vecs[$];

    switch_debounce_3 #(
        .N(3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .sw       (sw),
        .db_level (db_level),
        .db_tick  (db_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: level/tick got %b/%b expected %b/%b",
                     name, $time, act[5:3], act[2:0], exp[5:3], exp[2:0]);
        end
    endtask

    // Called at a negedge: holds sw for n clocks, checking outputs at every negedge.
    task automatic run_vec(input string name, input vec_t v);
        for (int k = 0; k < v.n; k++) begin
            sw = v.sw;
            @(negedge clk);
            check(name, {db_level, db_tick}, {v.level, v.tick});
        end
    endtask

    function automatic vec_t mk(input logic [2:0] s, input int n,
                                input logic [2:0] lv, input logic [2:0] tk);
        vec_t v;
        v.sw = s; v.n = n; v.level = lv; v.tick = tk;
        return v;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        sw     = 3'b111;

        // Test 1: reset holds outputs low even with all switches high.
        repeat (3) @(negedge clk);
        check("reset_state", {db_level, db_tick}, 6'b000_000);
        reset = 1'b0;

        vecs.push_back(mk(3'b111, C_LAT,     3'b000, 3'b000));
        vecs.push_back(mk(3'b111, 1,         3'b111, 3'b111));
        vecs.push_back(mk(3'b111, 3,         3'b111, 3'b000));
        vecs.push_back(mk(3'b000, C_LAT,     3'b111, 3'b000));
        vecs.push_back(mk(3'b000, 2,         3'b000, 3'b000));
        // Test 2: 5-cycle pulse on ch0 is rejected.
        vecs.push_back(mk(3'b001, 5,         3'b000, 3'b000));
        vecs.push_back(mk(3'b000, C_LAT + 2, 3'b000, 3'b000));
        // Test 3: bounce on ch1, then a clean hold.
        vecs.push_back(mk(3'b010, 2,         3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 2,         3'b000, 3'b000));
        vecs.push_back(mk(3'b010, 2,         3'b000, 3'b000));
        vecs.push_back(mk(3'b000, 2,         3'b000, 3'b000));
        vecs.push_back(mk(3'b010, C_LAT,     3'b000, 3'b000));
        vecs.push_back(mk(3'b010, 1,         3'b010, 3'b010));
        vecs.push_back(mk(3'b010, 2,         3'b010, 3'b000));
        vecs.push_back(mk(3'b000, C_LAT,     3'b010, 3'b000));
        vecs.push_back(mk(3'b000, 2,         3'b000, 3'b000));
        // Test 4: ch2 dip while high is absorbed, then a real release.
        vecs.push_back(mk(3'b100, C_LAT,     3'b000, 3'b000));
        vecs.push_back(mk(3'b100, 1,         3'b100, 3'b100));
        vecs.push_back(mk(3'b100, 2,         3'b100, 3'b000));
        vecs.push_back(mk(3'b000, 3,         3'b100, 3'b000));
        vecs.push_back(mk(3'b100, C_LAT + 3, 3'b100, 3'b000));
        vecs.push_back(mk(3'b000, C_LAT,     3'b100, 3'b000));
        vecs.push_back(mk(3'b000, 2,         3'b000, 3'b000));
        // Test 6: two channels rise together, the third stays low.
        vecs.push_back(mk(3'b101, C_LAT,     3'b000, 3'b000));
        vecs.push_back(mk(3'b101, 1,         3'b101, 3'b101));
        vecs.push_back(mk(3'b101, 2,         3'b101, 3'b000));
        vecs.push_back(mk(3'b000, C_LAT,     3'b101, 3'b000));
        vecs.push_back(mk(3'b000, 2,         3'b000, 3'b000));

        foreach (vecs[i]) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
        end

        // Test 5: reset while ch0 is mid-window (cnt=3) and ch2 is high.
        run_vec("t5_ch2_wait", mk(3'b100, C_LAT, 3'b000, 3'b000));
        run_vec("t5_ch2_rise", mk(3'b100, 1,     3'b100, 3'b100));
        run_vec("t5_ch0_cnt3", mk(3'b101, C_SYNC + 5, 3'b100, 3'b000));
        reset = 1'b1;
        #1;
        check("t5_async_clear", {db_level, db_tick}, 6'b000_000);
        @(negedge clk);
        check("t5_held_clear", {db_level, db_tick}, 6'b000_000);
        reset = 1'b0;
        run_vec("t5_restart_wait", mk(3'b101, C_LAT, 3'b000, 3'b000));
        run_vec("t5_restart_rise", mk(3'b101, 1,     3'b101, 3'b101));
        run_vec("t5_restart_hold", mk(3'b101, 2,     3'b101, 3'b000));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
